a_edge_logger: RTL and testbench

- Consumer stage for the single-bit output `a` of the `testing` block.
- Synchronises `a`, detects its rising edges and timestamps each one with a free-running cycle counter.
- Queues the timestamps in a small FIFO, drained by a valid/ready handshake toward downstream logic or a bench monitor.
- Also keeps a saturating total-edge count and a sticky overflow flag.

---
 rtl/a_edge_logger.sv | 58 +++++
 tb/tb_a_edge_logger.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/a_edge_logger.sv
// a_edge_logger: synchronises a_in, timestamps its rising edges into a FIFO, counts edges and flags drops
module a_edge_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [TS_W-1:0]  evt_data,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow,
  input  logic             ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  logic s1, s2, s2_d;
  logic rise, full, empty, pop, push, drop;
  logic [TS_W-1:0] ts;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [TS_W-1:0] mem [DEPTH];
  assign rise = s2 & ~s2_d;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop = ~empty & evt_ready;
  assign push = rise & (~full | pop);
  assign drop = rise & full & ~pop;
  assign evt_valid = ~empty;
  assign evt_data = mem[rd_ptr[AW-1:0]];
  // two-flop synchroniser followed by a delayed copy for rising-edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1, s2, s2_d} <= '0;
    else {s1, s2, s2_d} <= {a_in, s1, s2};
  // free-running cycle counter used as the timestamp source
  always_ff @(posedge clk or posedge rst)
    if (rst) ts <= '0;
    else ts <= ts + TS_W'(1);
  // timestamp storage; cleared on reset so the idle head reads as zero
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (push) mem[wr_ptr[AW-1:0]] <= ts;
  // FIFO pointers with a wrap bit to tell full from empty
  always_ff @(posedge clk or posedge rst)
    if (rst) {wr_ptr, rd_ptr} <= '0;
    else begin
      wr_ptr <= push ? wr_ptr + (AW+1)'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + (AW+1)'(1) : rd_ptr;
    end
  // saturating count of every detected edge, dropped ones included
  always_ff @(posedge clk or posedge rst)
    if (rst) evt_count <= '0;
    else if (rise && evt_count != '1) evt_count <= evt_count + CNT_W'(1);
  // sticky drop flag; a new drop takes priority over a clear in the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) overflow <= 1'b0;
    else overflow <= drop | (overflow & ~ovf_clr);
endmodule

// File: tb/tb_a_edge_logger.sv
// tb_a_edge_logger: vector table, hand sequences and randomised model comparison for a_edge_logger
module tb_a_edge_logger;
  logic clk, rst, a_in, evt_ready, ovf_clr, evt_valid, overflow;
  logic [15:0] evt_data;
  logic [7:0] evt_count;
  logic a_w, rdy_w, clr_w, valid_w, ovf_w;
  logic [3:0] data_w;
  logic [1:0] count_w;
  int checks = 0;
  int failures = 0;

  a_edge_logger dut (
    .clk(clk), .rst(rst), .a_in(a_in), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_data(evt_data), .evt_count(evt_count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  a_edge_logger #(.TS_W(4), .DEPTH(4), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .a_in(a_w), .evt_valid(valid_w), .evt_ready(rdy_w),
    .evt_data(data_w), .evt_count(count_w), .overflow(ovf_w), .ovf_clr(clr_w)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // reference model: an edge is a sample of 1 following a sample of 0; it is
  // enqueued two edges after it is sampled, stamped with the edge number minus one
  int n;
  bit samp[$];
  logic [15:0] q[$];
  int mcnt;
  bit movf;

  task automatic model_reset();
    n = 0;
    samp.delete();
    samp.push_back(1'b0);
    q.delete();
    mcnt = 0;
    movf = 0;
  endtask

  task automatic model_step(bit a, bit rdy, bit clr);
    bit rs, dr;
    n++;
    samp.push_back(a);
    rs = (n >= 3) && samp[n-2] && !samp[n-3];
    dr = 0;
    if (rdy && q.size() > 0) void'(q.pop_front());
    if (rs) begin
      if (q.size() < 4) q.push_back(16'(n - 1));
      else dr = 1;
      if (mcnt < 255) mcnt++;
    end
    movf = dr | (movf & !clr);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic check_model(string nm);
    chk({nm, "_valid"}, 32'(evt_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk({nm, "_data"}, 32'(evt_data), 32'(q[0]));
    chk({nm, "_count"}, 32'(evt_count), 32'(mcnt));
    chk({nm, "_ovf"}, 32'(overflow), 32'(movf));
  endtask

  task automatic cycle(bit a, bit rdy, bit clr);
    a_in = a;
    evt_ready = rdy;
    ovf_clr = clr;
    @(posedge clk);
    model_step(a, rdy, clr);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    a_in = 0; evt_ready = 0; ovf_clr = 0;
    a_w = 0; rdy_w = 0; clr_w = 0;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic fill_five();
    for (int i = 0; i < 24; i++) cycle(i < 18 && (i % 4) < 2, 0, 0);
  endtask

  typedef struct {
    bit a, rdy, clr;
    bit v;
    logic [15:0] d;
    int c;
    bit o;
  } vec_t;
  vec_t tbl[8];

  initial begin
    logic [3:0] wexp[4];
    bit ra;
    int thr;
    tbl[0] = '{1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 0, 1, 2, 1, 0};
    tbl[3] = '{0, 1, 0, 0, 0, 1, 0};
    tbl[4] = '{0, 1, 0, 0, 0, 1, 0};
    tbl[5] = '{1, 0, 0, 0, 0, 1, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 1, 0};
    tbl[7] = '{0, 0, 0, 1, 7, 2, 0};
    wexp = '{4'd12, 4'd14, 4'd0, 4'd2};

    do_reset();
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_data", 32'(evt_data), 0);
    chk("rst_count", 32'(evt_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_w_count", 32'(count_w), 0);

    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].a, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("vec%0d_valid", i), 32'(evt_valid), 32'(tbl[i].v));
      if (tbl[i].v) chk($sformatf("vec%0d_data", i), 32'(evt_data), 32'(tbl[i].d));
      chk($sformatf("vec%0d_count", i), 32'(evt_count), 32'(tbl[i].c));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(tbl[i].o));
    end

    do_reset();
    fill_five();
    chk("ovf_count", 32'(evt_count), 5);
    chk("ovf_flag", 32'(overflow), 1);
    for (int j = 0; j < 4; j++) begin
      chk("ovf_drain_valid", 32'(evt_valid), 1);
      chk("ovf_drain_data", 32'(evt_data), 32'(2 + 4 * j));
      cycle(0, 1, 0);
    end
    chk("ovf_drained", 32'(evt_valid), 0);
    chk("ovf_still_set", 32'(overflow), 1);
    cycle(0, 0, 1);
    chk("ovf_cleared", 32'(overflow), 0);

    do_reset();
    for (int i = 0; i < 22; i++) cycle(i < 18 && (i % 4) < 2, i == 18, 0);
    chk("fullpop_ovf", 32'(overflow), 0);
    chk("fullpop_count", 32'(evt_count), 5);
    for (int j = 0; j < 4; j++) begin
      chk("fullpop_valid", 32'(evt_valid), 1);
      chk("fullpop_data", 32'(evt_data), 32'(6 + 4 * j));
      cycle(0, 1, 0);
    end
    chk("fullpop_empty", 32'(evt_valid), 0);

    do_reset();
    for (int i = 0; i < 23; i++) begin
      a_w = (i == 10 || i == 12 || i == 14 || i == 16);
      cycle(0, 0, 0);
    end
    chk("wrap_count_sat", 32'(count_w), 3);
    chk("wrap_ovf", 32'(ovf_w), 0);
    for (int j = 0; j < 4; j++) begin
      chk("wrap_valid", 32'(valid_w), 1);
      chk("wrap_data", 32'(data_w), 32'(wexp[j]));
      rdy_w = 1;
      cycle(0, 0, 0);
      rdy_w = 0;
    end
    chk("wrap_empty", 32'(valid_w), 0);

    do_reset();
    fill_five();
    cycle(0, 1, 0);
    check_model("midrst_pre");
    #3;
    rst = 1;
    #1;
    chk("midrst_valid", 32'(evt_valid), 0);
    chk("midrst_ovf", 32'(overflow), 0);
    chk("midrst_count", 32'(evt_count), 0);
    chk("midrst_data", 32'(evt_data), 0);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    chk("midrst_after_valid", 32'(evt_valid), 1);
    chk("midrst_after_data", 32'(evt_data), 2);
    chk("midrst_after_count", 32'(evt_count), 1);

    do_reset();
    for (int i = 0; i < 50; i++) cycle(1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    chk("level_count", 32'(evt_count), 1);
    chk("level_data", 32'(evt_data), 2);
    cycle(0, 1, 0);
    chk("level_single", 32'(evt_valid), 0);
    a_in = 1;
    #1;
    a_in = 0;
    for (int i = 0; i < 5; i++) cycle(0, 0, 0);
    chk("glitch_count", 32'(evt_count), 1);
    chk("glitch_valid", 32'(evt_valid), 0);

    do_reset();
    ra = 0;
    thr = 8;
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) thr = (thr == 8) ? 2 : 8;
      if ($urandom_range(0, 2) == 0) ra = !ra;
      cycle(ra, $urandom_range(0, 9) < thr, $urandom_range(0, 19) == 0);
      check_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
